// File: rtl/cmsdk_fpga_sram_dp.sv
// cmsdk_fpga_sram_dp: dual-port on-chip SRAM; port A byte-lane read/write, port B read-only.
// Latency: read data + RVALID RDLAT (1 or 2) cycles after the request edge; writes land on the request edge.
// Backpressure: none; both ports accept a request every cycle. Optional lane parity: CMSDK_FPGA_SRAM_PARITY_EN.
module cmsdk_fpga_sram_dp #(
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int RDLAT = 1
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          A_CS,
  input  logic [AW-$clog2(DW/8)-1:0]    A_ADDR,
  input  logic [DW/8-1:0]               A_WREN,
  input  logic [DW-1:0]                 A_WDATA,
  output logic [DW-1:0]                 A_RDATA,
  output logic                          A_RVALID,
  input  logic                          B_CS,
  input  logic [AW-$clog2(DW/8)-1:0]    B_ADDR,
  output logic [DW-1:0]                 B_RDATA,
  output logic                          B_RVALID,
  output logic [1:0]                    PERR
);

  localparam int NB    = DW / 8;
  localparam int LB    = $clog2(NB);
  localparam int WAW   = AW - LB;
  localparam int DEPTH = 2 ** WAW;

  // Elaboration-time parameter sanity.
  if ((DW % 8) != 0 || DW < 8 || DW > 128) begin : g_bad_dw
    $error("cmsdk_fpga_sram_dp: DW must be a multiple of 8 in 8..128");
  end
  if (RDLAT != 1 && RDLAT != 2) begin : g_bad_rdlat
    $error("cmsdk_fpga_sram_dp: RDLAT must be 1 or 2");
  end

  // Storage array; deliberately never reset or initialised so it maps onto block RAM.
  logic [DW-1:0] mem_q [DEPTH];

  // Raw registered array reads (no read enable on this path, as block RAM prefers).
  logic [DW-1:0] a_arr_q;
  logic [DW-1:0] b_arr_q;

  // Stage-1 request tracking and collision forwarding state.
  logic          a_vld1_q, a_vld1_d;
  logic          b_vld1_q, b_vld1_d;
  logic [NB-1:0] fwd_lane_q, fwd_lane_d;
  logic [DW-1:0] fwd_dat_q;

  // Lane write strobes; inputs are ignored while in reset.
  logic [NB-1:0] we;
  assign we = (A_CS && !RESET) ? A_WREN : '0;

  // Port B data after the write-first per-byte merge.
  logic [DW-1:0] b_dat1;

  // Lane parity mismatch summaries for the stage-1 data.
  logic a_err;
  logic b_err;
  logic [1:0] perr1;

  // Array write (per lane) and registered reads for both ports.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem_q[A_ADDR][8*i +: 8] <= A_WDATA[8*i +: 8];
    end
    a_arr_q <= mem_q[A_ADDR];
    b_arr_q <= mem_q[B_ADDR];
  end

  // Next-state for the stage-1 valid flags and the collision lane mask.
  always_comb begin
    a_vld1_d   = A_CS && (A_WREN == '0);
    b_vld1_d   = B_CS;
    fwd_lane_d = '0;
    if (A_CS && B_CS && (A_ADDR == B_ADDR)) fwd_lane_d = A_WREN;
  end

  // Stage-1 control registers; a reset drops any in-flight read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a_vld1_q   <= 1'b0;
      b_vld1_q   <= 1'b0;
      fwd_lane_q <= '0;
      fwd_dat_q  <= '0;
    end else begin
      a_vld1_q   <= a_vld1_d;
      b_vld1_q   <= b_vld1_d;
      fwd_lane_q <= fwd_lane_d;
      if (|fwd_lane_d) fwd_dat_q <= A_WDATA;
    end
  end

  // Same-cycle A-write/B-read: written lanes come from the write data, others from the array.
  always_comb begin
    b_dat1 = b_arr_q;
    for (int i = 0; i < NB; i++) begin
      if (fwd_lane_q[i]) b_dat1[8*i +: 8] = fwd_dat_q[8*i +: 8];
    end
  end

`ifdef CMSDK_FPGA_SRAM_PARITY_EN
  // One even-parity bit per byte lane, stored beside the data word.
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] a_par1_q;
  logic [NB-1:0] b_par1_q;

  // Parity write (with its lane) and registered parity reads.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) par_q[A_ADDR][i] <= ^A_WDATA[8*i +: 8];
    end
    a_par1_q <= par_q[A_ADDR];
    b_par1_q <= par_q[B_ADDR];
  end

  // Recompute lane parity; forwarded lanes carry fresh parity so can never mismatch.
  always_comb begin
    a_err = 1'b0;
    b_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      a_err = a_err | ((^a_arr_q[8*i +: 8]) ^ a_par1_q[i]);
      b_err = b_err | (((^b_arr_q[8*i +: 8]) ^ b_par1_q[i]) & ~fwd_lane_q[i]);
    end
  end
`else
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

  // Errors are only reported alongside a valid read.
  assign perr1 = {b_vld1_q & b_err, a_vld1_q & a_err};

  if (RDLAT == 2) begin : g_lat2
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;
    logic          a_rvalid_q;
    logic          b_rvalid_q;
    logic [1:0]    perr_q;

    // Output register stage; data only loads on a valid read so it holds otherwise.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        a_rdata_q  <= '0;
        b_rdata_q  <= '0;
        a_rvalid_q <= 1'b0;
        b_rvalid_q <= 1'b0;
        perr_q     <= 2'b00;
      end else begin
        a_rvalid_q <= a_vld1_q;
        b_rvalid_q <= b_vld1_q;
        perr_q     <= perr1;
        if (a_vld1_q) a_rdata_q <= a_arr_q;
        if (b_vld1_q) b_rdata_q <= b_dat1;
      end
    end

    assign A_RDATA  = a_rdata_q;
    assign B_RDATA  = b_rdata_q;
    assign A_RVALID = a_rvalid_q;
    assign B_RVALID = b_rvalid_q;
    assign PERR     = perr_q;
  end else begin : g_lat1
    // Single-cycle latency: outputs are gated to zero when no read is valid.
    assign A_RDATA  = a_vld1_q ? a_arr_q : '0;
    assign B_RDATA  = b_vld1_q ? b_dat1 : '0;
    assign A_RVALID = a_vld1_q;
    assign B_RVALID = b_vld1_q;
    assign PERR     = perr1;
  end

endmodule

// File: tb/tb_cmsdk_fpga_sram_dp.sv
// Bench for cmsdk_fpga_sram_dp: RDLAT=1 and RDLAT=2 instances share one stimulus stream.
// Expected outputs come from a word-array memory model plus a two-deep result history.
// Directed cases first, then randomized traffic with frequent same-address collisions.
module tb_cmsdk_fpga_sram_dp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_cs = 1'b0;
  logic        b_cs = 1'b0;
  logic [13:0] a_addr = '0;
  logic [13:0] b_addr = '0;
  logic [3:0]  a_wren = '0;
  logic [31:0] a_wdata = '0;

  logic [31:0] a_rd1, b_rd1, a_rd2, b_rd2;
  logic        a_rv1, b_rv1, a_rv2, b_rv2;
  logic [1:0]  perr1, perr2;

  int tests = 0;
  int fails = 0;

  // Behavioural model: memory contents, corrupted-lane marks, result history.
  logic [31:0] mdl [64];
  logic [3:0]  bad [64];
  bit          chk_dat = 1'b1;
  bit          p_av, p_bv, p_ae, p_be;
  logic [31:0] p_ad, p_bd;
  bit          q_av, q_bv, q_ae, q_be;
  logic [31:0] h_ad, h_bd;

  always #5 clk = ~clk;

  cmsdk_fpga_sram_dp #(.AW(16), .DW(32), .RDLAT(1)) dut1 (
    .CLK(clk), .RESET(rst),
    .A_CS(a_cs), .A_ADDR(a_addr), .A_WREN(a_wren), .A_WDATA(a_wdata),
    .A_RDATA(a_rd1), .A_RVALID(a_rv1),
    .B_CS(b_cs), .B_ADDR(b_addr), .B_RDATA(b_rd1), .B_RVALID(b_rv1),
    .PERR(perr1)
  );

  cmsdk_fpga_sram_dp #(.AW(16), .DW(32), .RDLAT(2)) dut2 (
    .CLK(clk), .RESET(rst),
    .A_CS(a_cs), .A_ADDR(a_addr), .A_WREN(a_wren), .A_WDATA(a_wdata),
    .A_RDATA(a_rd2), .A_RVALID(a_rv2),
    .B_CS(b_cs), .B_ADDR(b_addr), .B_RDATA(b_rd2), .B_RVALID(b_rv2),
    .PERR(perr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_cs = 1'b0; b_cs = 1'b0; a_wren = 4'h0;
  endtask

  // One clock: update the model at the edge, then compare both instances.
  task automatic step();
    int ai, bi;
    @(posedge clk);
    if (rst) begin
      p_av = 0; p_bv = 0; p_ae = 0; p_be = 0; p_ad = '0; p_bd = '0;
      q_av = 0; q_bv = 0; q_ae = 0; q_be = 0; h_ad = '0; h_bd = '0;
    end else begin
      ai = int'(a_addr[5:0]);
      bi = int'(b_addr[5:0]);
      q_av = p_av; q_bv = p_bv;
      q_ae = p_av && p_ae; q_be = p_bv && p_be;
      if (p_av) h_ad = p_ad;
      if (p_bv) h_bd = p_bd;
      // Write first: a same-cycle read of the written word sees the new lanes.
      if (a_cs) begin
        for (int l = 0; l < 4; l++) begin
          if (a_wren[l]) begin
            mdl[ai][8*l +: 8] = a_wdata[8*l +: 8];
            bad[ai][l] = 1'b0;
          end
        end
      end
      p_av = a_cs && (a_wren == 4'h0);
      p_ad = mdl[ai];
      p_ae = |bad[ai];
      p_bv = b_cs;
      p_bd = mdl[bi];
      p_be = |bad[bi];
    end
    #1;
    chk("a_rvalid_l1", 32'(a_rv1), 32'(p_av));
    chk("b_rvalid_l1", 32'(b_rv1), 32'(p_bv));
    chk("a_rvalid_l2", 32'(a_rv2), 32'(q_av));
    chk("b_rvalid_l2", 32'(b_rv2), 32'(q_bv));
    if (chk_dat) begin
      chk("a_rdata_l1", a_rd1, p_av ? p_ad : 32'h0);
      chk("b_rdata_l1", b_rd1, p_bv ? p_bd : 32'h0);
      chk("a_rdata_l2", a_rd2, h_ad);
      chk("b_rdata_l2", b_rd2, h_bd);
      chk("perr_l1", 32'(perr1), 32'({p_bv && p_be, p_av && p_ae}));
      chk("perr_l2", 32'(perr2), 32'({q_be, q_ae}));
    end
  endtask

  initial begin
    logic [1:0] exp_perr;
    for (int i = 0; i < 64; i++) begin
      mdl[i] = '0;
      bad[i] = 4'h0;
    end

    // Reset: every output must be zero while reset is held.
    rst = 1'b1;
    repeat (3) step();
    chk("reset_a_rdata", a_rd2, 32'h0);
    rst = 1'b0;
    step();

    // First read of an unwritten word: only the strobes are defined.
    chk_dat = 1'b0;
    a_cs = 1'b1; a_addr = 14'd5;
    step();
    idle();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_dat = 1'b1;
    step();

    // Preload words 0..63 (0..7 with addr*0x11).
    for (int i = 0; i < 64; i++) begin
      a_cs = 1'b1; a_wren = 4'hF; a_addr = 14'(i);
      a_wdata = (i < 8) ? 32'(i) * 32'h11 : $urandom;
      step();
    end
    idle();
    step();

    // Full write then single-lane partial write, then read back.
    a_cs = 1'b1; a_addr = 14'h10; a_wren = 4'hF; a_wdata = 32'hA5A5_5A5A;
    step();
    a_wren = 4'b0010; a_wdata = 32'h0000_3C00;
    step();
    a_wren = 4'h0;
    step();
    chk("partial_wr_l1", a_rd1, 32'hA5A5_3C5A);
    idle();
    step();
    chk("partial_wr_l2", a_rd2, 32'hA5A5_3C5A);

    // Back-to-back reads on both ports.
    for (int i = 0; i < 8; i++) begin
      a_cs = 1'b1; a_wren = 4'h0; a_addr = 14'(i);
      b_cs = 1'b1; b_addr = 14'(7 - i);
      step();
      chk("b2b_a_l1", a_rd1, 32'(i) * 32'h11);
      chk("b2b_b_l1", b_rd1, 32'(7 - i) * 32'h11);
    end
    idle();
    step();
    step();

    // Collision: same-address write and B read merge per byte; other address untouched.
    a_cs = 1'b1; a_addr = 14'h20; a_wren = 4'hF; a_wdata = 32'hFFFF_FFFF;
    step();
    a_wren = 4'b1100; a_wdata = 32'h1122_3344;
    b_cs = 1'b1; b_addr = 14'h20;
    step();
    chk("collide_l1", b_rd1, 32'h1122_FFFF);
    a_wren = 4'b0011; a_wdata = 32'h5566_7788;
    b_addr = 14'h24;
    step();
    chk("collide_l2", b_rd2, 32'h1122_FFFF);
    idle();
    step();
    step();

    // Reset one cycle after a read request drops it.
    a_cs = 1'b1; a_addr = 14'h10; a_wren = 4'h0;
    step();
    idle();
    rst = 1'b1;
    step();
    chk("reset_drop_rv_l2", 32'(a_rv2), 32'h0);
    step();
    rst = 1'b0;
    step();

    // Parity: corrupt bit 9 of word 0x30, read on both ports.
`ifdef CMSDK_FPGA_SRAM_PARITY_EN
    dut1.mem_q[48][9] = ~dut1.mem_q[48][9];
    dut2.mem_q[48][9] = ~dut2.mem_q[48][9];
    mdl[48][9] = ~mdl[48][9];
    bad[48][1] = 1'b1;
    exp_perr = 2'b01;
`else
    exp_perr = 2'b00;
`endif
    a_cs = 1'b1; a_addr = 14'h30; a_wren = 4'h0;
    b_cs = 1'b1; b_addr = 14'h31;
    step();
    chk("perr_flip_l1", 32'(perr1), 32'(exp_perr));
    idle();
    step();
    chk("perr_flip_l2", 32'(perr2), 32'(exp_perr));
    step();

    // Randomized traffic with frequent address collisions and one reset pulse.
    for (int n = 0; n < 400; n++) begin
      a_cs    = ($urandom_range(0, 3) != 0);
      a_wren  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      a_wdata = $urandom;
      a_addr  = 14'($urandom_range(0, 63));
      b_cs    = ($urandom_range(0, 3) != 0);
      b_addr  = ($urandom_range(0, 2) == 0) ? a_addr : 14'($urandom_range(0, 63));
      rst     = (n == 200);
      step();
    end
    rst = 1'b0;
    idle();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
